serial_add_ctrl: RTL

//  Bit-serial adder controller. Sequences one full_adder cell over WIDTH clocks, LSB first,
//  to add two WIDTH-bit operands. A carry flip-flop holds the carry between bits.

---
 rtl/serial_add_ctrl_pkg.sv | 15 +
 rtl/serial_add_ctrl_full_adder.sv | 19 +
 rtl/serial_add_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg
//   Shared constants and types for the bit-serial adder controller.
//   - DEFAULT_WIDTH : default operand/sum width
//   - state_t       : controller state encodings (IDLE=0, SHIFT=1, DONE=2)
package serial_add_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// serial_add_ctrl_full_adder
//   Single-bit full adder cell, purely combinational.
//   Ports:
//     i_a, i_b : operand bits
//     i_c      : carry in
//     o_s      : sum bit
//     o_c      : carry out
module serial_add_ctrl_full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder controller. One full-adder cell is sequenced over WIDTH clocks,
//   LSB first, with a carry flip-flop between bits. start/busy/done handshake,
//   parallel sum out.
//   Optional feature macro: SERIAL_ADD_OVF_EN adds the signed-overflow output o_ovf.
//   Parameters:
//     WIDTH   : operand/sum width, 2..64
//   Ports:
//     i_clk   : clock, rising edge
//     i_rst   : synchronous active-high reset
//     i_start : request, sampled only in IDLE
//     i_a/i_b : operands, captured on accepted start
//     i_cin   : carry in, captured on accepted start
//     o_busy  : high while shifting
//     o_done  : one-cycle pulse, result valid from this cycle
//     o_sum   : result register (not valid while busy)
//     o_cout  : final carry out
//     o_ovf   : signed overflow (SERIAL_ADD_OVF_EN builds only)
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
        $error("serial_add_ctrl: WIDTH must be in 2..64");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_areg;
    logic [WIDTH-1:0] r_breg;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             r_ovf;
`endif

    logic             w_s;
    logic             w_c;

    serial_add_ctrl_full_adder u_fa (
        .i_a (r_areg[0]),
        .i_b (r_breg[0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_c)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_areg  <= '0;
            r_breg  <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_areg  <= i_a;
                        r_breg  <= i_b;
                        r_carry <= i_cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Sum bits enter at the MSB and migrate down; after WIDTH shifts the
                    // first (LSB) result bit has reached bit 0.
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_c;
                    r_areg  <= r_areg >> 1;
                    r_breg  <= r_breg >> 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cout  <= w_c;
`ifdef SERIAL_ADD_OVF_EN
                        // On the MSB step r_carry is the carry into the MSB.
                        r_ovf   <= r_carry ^ w_c;
`endif
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
    assign o_ovf  = r_ovf;
`endif

endmodule
